// File: rtl/wb_tg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_tg_pkg
// Description : Shared constants and types for the Wishbone traffic generator:
//               cycle-type / burst-type encodings, FSM state type and the
//               LFSR feedback polynomial.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_tg_pkg;

   // Wishbone registered-feedback cycle type identifiers
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Wishbone burst type extensions (wrap size)
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_4       = 2'b01;
   localparam logic [1:0] BTE_8       = 2'b10;
   localparam logic [1:0] BTE_16      = 2'b11;

   // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
   localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR     = 3'd1,
      ST_WR_GAP = 3'd2,
      ST_RD     = 3'd3,
      ST_RD_GAP = 3'd4,
      ST_FIN    = 3'd5
   } tg_state_e;

   // Burst type matching a burst length; single beats use linear/classic
   function automatic logic [1:0] bte_for(input int unsigned burst_len);
      case (burst_len)
         4:       bte_for = BTE_4;
         8:       bte_for = BTE_8;
         16:      bte_for = BTE_16;
         default: bte_for = BTE_LINEAR;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_tg_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : wb_tg_lfsr
// Description : 32-bit Galois LFSR with synchronous reload and step enable.
//               Reload wins over step when both are requested.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_tg_lfsr
   import wb_tg_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic        step_i,
   output logic [31:0] value_o
);

   logic [31:0] lfsr_q;
   logic [31:0] lfsr_d;

   // Next value: reload to the seed, or shift with feedback from bit 0
   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED;
      end else if (step_i) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
      end
   end

   // State register, seeded on reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/wb_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : wb_traffic_gen
// Description : Wishbone burst traffic generator. One pass writes NR_BURSTS
//               bursts of LFSR data, then reads the same addresses back and
//               counts data mismatches. Stalled beats abort after TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_traffic_gen
   import wb_tg_pkg::*;
#(
   parameter int unsigned ADR_W     = 32,
   parameter int unsigned DAT_W     = 32,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned NR_BURSTS = 16,
   parameter int unsigned BASE_ADR  = 0,
   parameter logic [31:0] SEED      = 32'h1,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic               wb_clk,
   input  logic               wb_rst_n,
   output logic [ADR_W-1:0]   wb_adr_o,
   output logic [DAT_W-1:0]   wb_dat_o,
   output logic [DAT_W/8-1:0] wb_sel_o,
   output logic               wb_we_o,
   output logic [2:0]         wb_cti_o,
   output logic [1:0]         wb_bte_o,
   output logic               wb_cyc_o,
   output logic               wb_stb_o,
   input  logic [DAT_W-1:0]   wb_dat_i,
   input  logic               wb_ack_i,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic [15:0]        err_cnt
);

   localparam int unsigned SEL_W   = DAT_W / 8;
   localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned BURST_W = (NR_BURSTS > 1) ? $clog2(NR_BURSTS) : 1;
   localparam int unsigned WAIT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [1:0]  C_BTE   = bte_for(BURST_LEN);

   tg_state_e           state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [BURST_W-1:0]  burst_q, burst_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [15:0]         err_q, err_d;
   logic                tmo_q, tmo_d;

   logic                w_active;
   logic                w_last_beat;
   logic                w_last_burst;
   logic                w_lfsr_load;
   logic                w_lfsr_step;
   logic [31:0]         w_lfsr;
   logic [DAT_W-1:0]    w_pat;
   logic [ADR_W-1:0]    w_adr;

   wb_tg_lfsr #(
      .SEED    (SEED)
   ) u_lfsr (
      .clk_i   (wb_clk),
      .rst_ni  (wb_rst_n),
      .load_i  (w_lfsr_load),
      .step_i  (w_lfsr_step),
      .value_o (w_lfsr)
   );

   // Fit the 32-bit LFSR word to the bus width
   generate
      if (DAT_W <= 32) begin : g_pat_trunc
         assign w_pat = w_lfsr[DAT_W-1:0];
      end else begin : g_pat_repl
         assign w_pat = {(DAT_W/32){w_lfsr}};
      end
   endgenerate

   assign w_active     = (state_q == ST_WR) || (state_q == ST_RD);
   assign w_last_beat  = (beat_q == BEAT_W'(BURST_LEN - 1));
   assign w_last_burst = (burst_q == BURST_W'(NR_BURSTS - 1));
   assign w_adr        = ADR_W'(BASE_ADR)
                       + (ADR_W'(burst_q) * ADR_W'(BURST_LEN) + ADR_W'(beat_q))
                       * ADR_W'(SEL_W);

   // Sequencer: beat/burst counters, ack-wait watchdog, read check
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      burst_d     = burst_q;
      wait_d      = wait_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      w_lfsr_load = 1'b0;
      w_lfsr_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_WR;
               beat_d      = '0;
               burst_d     = '0;
               wait_d      = '0;
               err_d       = '0;
               tmo_d       = 1'b0;
               w_lfsr_load = 1'b1;
            end
         end
         ST_WR, ST_RD: begin
            if (wb_ack_i) begin
               wait_d      = '0;
               w_lfsr_step = 1'b1;
               if ((state_q == ST_RD) && (wb_dat_i != w_pat) && (err_q != 16'hFFFF)) begin
                  err_d = err_q + 16'd1;
               end
               if (w_last_beat) begin
                  beat_d = '0;
                  if (w_last_burst) begin
                     burst_d = '0;
                     if (state_q == ST_WR) begin
                        // Read phase replays the same data sequence
                        state_d     = ST_RD;
                        w_lfsr_load = 1'b1;
                     end else begin
                        state_d = ST_FIN;
                     end
                  end else begin
                     burst_d = burst_q + BURST_W'(1);
                     state_d = (state_q == ST_WR) ? ST_WR_GAP : ST_RD_GAP;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end else if (wait_q == WAIT_W'(TIMEOUT)) begin
               state_d = ST_FIN;
               tmo_d   = 1'b1;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_WR_GAP: state_d = ST_WR;
         ST_RD_GAP: state_d = ST_RD;
         ST_FIN:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State and counter registers
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         burst_q <= '0;
         wait_q  <= '0;
         err_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   // Bus outputs are decoded from state so they drop with the async reset
   always_comb begin
      wb_cyc_o = w_active;
      wb_stb_o = w_active;
      wb_we_o  = (state_q == ST_WR);
      wb_sel_o = {SEL_W{w_active}};
      wb_adr_o = w_active ? w_adr : '0;
      wb_dat_o = (state_q == ST_WR) ? w_pat : '0;
      wb_bte_o = w_active ? C_BTE : BTE_LINEAR;
      if (!w_active || (BURST_LEN == 1)) begin
         wb_cti_o = CTI_CLASSIC;
      end else if (w_last_beat) begin
         wb_cti_o = CTI_EOB;
      end else begin
         wb_cti_o = CTI_INC;
      end
      busy    = (state_q != ST_IDLE);
      done    = (state_q == ST_FIN);
      timeout = tmo_q;
      err_cnt = err_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_traffic_gen
// Description : Bench for wb_traffic_gen. A reference model expands each
//               accepted start into the expected beat list; slave models
//               answer the bus and monitors pop and compare completed beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_traffic_gen;

   localparam logic [31:0] SEED = 32'h1;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [2:0]  cti;
      logic [1:0]  bte;
   } beat_t;

   logic wb_clk = 1'b0;
   logic rst_n;

   // DUT0: default burst shape, short watchdog
   logic [31:0] adr0, dat0_o, dat0_i;
   logic [3:0]  sel0;
   logic [2:0]  cti0;
   logic [1:0]  bte0;
   logic        we0, cyc0, stb0, ack0, start0, busy0, done0, tmo0;
   logic [15:0] err0;

   // DUT1: single-beat classic cycles
   logic [31:0] adr1, dat1_o, dat1_i;
   logic [3:0]  sel1;
   logic [2:0]  cti1;
   logic [1:0]  bte1;
   logic        we1, cyc1, stb1, ack1, start1, busy1, done1, tmo1;
   logic [15:0] err1;

   int total = 0;
   int bad   = 0;

   beat_t q0[$];
   beat_t q1[$];
   logic [31:0] mem0 [logic [31:0]];
   logic [31:0] mem1 [logic [31:0]];

   int beats0 = 0, beats1 = 0;
   int wr_idx = 0, rd_idx = 0, hang_cycles = 0;
   bit stall_en = 0, spur_en = 0, corrupt_en = 0, noack_en = 0, poke_en = 0;

   always #5 wb_clk = ~wb_clk;

   wb_traffic_gen #(
      .ADR_W(32), .DAT_W(32), .BURST_LEN(4), .NR_BURSTS(16),
      .BASE_ADR(0), .SEED(SEED), .TIMEOUT(15)
   ) u_dut0 (
      .wb_clk(wb_clk), .wb_rst_n(rst_n),
      .wb_adr_o(adr0), .wb_dat_o(dat0_o), .wb_sel_o(sel0), .wb_we_o(we0),
      .wb_cti_o(cti0), .wb_bte_o(bte0), .wb_cyc_o(cyc0), .wb_stb_o(stb0),
      .wb_dat_i(dat0_i), .wb_ack_i(ack0),
      .start(start0), .busy(busy0), .done(done0), .timeout(tmo0), .err_cnt(err0)
   );

   wb_traffic_gen #(
      .ADR_W(32), .DAT_W(32), .BURST_LEN(1), .NR_BURSTS(8),
      .BASE_ADR(0), .SEED(SEED), .TIMEOUT(15)
   ) u_dut1 (
      .wb_clk(wb_clk), .wb_rst_n(rst_n),
      .wb_adr_o(adr1), .wb_dat_o(dat1_o), .wb_sel_o(sel1), .wb_we_o(we1),
      .wb_cti_o(cti1), .wb_bte_o(bte1), .wb_cyc_o(cyc1), .wb_stb_o(stb1),
      .wb_dat_i(dat1_i), .wb_ack_i(ack1),
      .start(start1), .busy(busy1), .done(done1), .timeout(tmo1), .err_cnt(err1)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Polynomial x^32+x^22+x^2+x+1: the bit leaving position 0 feeds back
   // into the taps for terms 32, 22, 2 and 1.
   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      logic fb;
      fb = x[0];
      x  = x >> 1;
      if (fb) x = x ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
      return x;
   endfunction

   // Expected beat list of one full pass (write phase then read phase),
   // truncated to the first cap beats.
   task automatic push_pass(input int which, input int bl, input int nb, input int cap);
      logic [31:0] l;
      beat_t       b;
      int          n;
      n = 0;
      for (int pass = 0; pass < 2; pass++) begin
         l = SEED;
         for (int i = 0; i < bl * nb; i++) begin
            b.we  = (pass == 0);
            b.adr = 32'(i * 4);
            b.dat = l;
            if (bl == 1)               b.cti = 3'b000;
            else if ((i % bl) == bl-1) b.cti = 3'b111;
            else                       b.cti = 3'b010;
            case (bl)
               4:       b.bte = 2'b01;
               8:       b.bte = 2'b10;
               16:      b.bte = 2'b11;
               default: b.bte = 2'b00;
            endcase
            if (n < cap) begin
               if (which == 0) q0.push_back(b);
               else            q1.push_back(b);
            end
            n++;
            l = lfsr_next(l);
         end
      end
   endtask

   task automatic pulse_start(input int which);
      @(negedge wb_clk);
      if (which == 0) start0 = 1'b1;
      else            start1 = 1'b1;
      @(negedge wb_clk);
      if (which == 0) start0 = 1'b0;
      else            start1 = 1'b0;
   endtask

   task automatic wait_done(input int which, input int limit, input string nm);
      bit seen;
      seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge wb_clk); #2;
         seen = (which == 0) ? done0 : done1;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_done: no done pulse within %0d cycles", nm, limit);
      end
      @(negedge wb_clk); #2;
      chk({nm, "_done_width"}, (which == 0) ? done0 : done1, 0);
      chk({nm, "_idle"},       (which == 0) ? busy0 : busy1, 0);
   endtask

   // Slave 0: memory with optional stalls, hang, read corruption, stray acks
   initial begin : slave0
      int stall;
      bit fresh;
      stall = 0;
      fresh = 1;
      ack0  = 1'b0;
      dat0_i = '0;
      forever begin
         @(negedge wb_clk);
         ack0   = 1'b0;
         dat0_i = '0;
         if (!rst_n) begin
            fresh = 1;
         end else if (stb0) begin
            if (fresh) begin
               stall = stall_en ? int'($urandom_range(0, 7)) : 0;
               fresh = 0;
            end
            if (noack_en && we0 && wr_idx == 3) begin
               hang_cycles++;
            end else if (stall > 0) begin
               stall--;
            end else begin
               ack0  = 1'b1;
               fresh = 1;
               if (we0) begin
                  mem0[adr0] = dat0_o;
                  wr_idx++;
               end else begin
                  dat0_i = mem0.exists(adr0) ? mem0[adr0] : 32'h0;
                  if (corrupt_en && (rd_idx == 5 || rd_idx == 40)) dat0_i[0] = ~dat0_i[0];
                  rd_idx++;
               end
            end
         end else begin
            fresh = 1;
            if (spur_en && $urandom_range(0, 1) == 1) ack0 = 1'b1;
         end
      end
   end

   // Slave 1: zero-wait memory
   initial begin : slave1
      ack1   = 1'b0;
      dat1_i = '0;
      forever begin
         @(negedge wb_clk);
         ack1   = stb1 && rst_n;
         dat1_i = '0;
         if (stb1 && we1)  mem1[adr1] = dat1_o;
         else if (stb1)    dat1_i = mem1.exists(adr1) ? mem1[adr1] : 32'h0;
      end
   end

   // Monitor 0: compare every completed beat, check inter-burst gaps
   initial begin : mon0
      beat_t e;
      int    low_run;
      low_run = 0;
      forever begin
         @(negedge wb_clk); #1;
         if (stb0 && ack0) begin
            if (q0.size() == 0) begin
               total++;
               bad++;
               $display("FAIL d0_extra_beat: got beat at adr %0h expected none", adr0);
            end else begin
               e = q0.pop_front();
               chk("d0_adr", adr0, e.adr);
               chk("d0_we",  we0,  e.we);
               chk("d0_cti", cti0, e.cti);
               chk("d0_bte", bte0, e.bte);
               chk("d0_sel", sel0, 4'hF);
               if (e.we) chk("d0_wdat", dat0_o, e.dat);
            end
            beats0++;
         end
         if (busy0 && !cyc0) begin
            low_run++;
         end else if (busy0 && cyc0) begin
            if (low_run > 0) chk("d0_gap", low_run, 1);
            low_run = 0;
         end else begin
            low_run = 0;
         end
      end
   end

   // Monitor 1: same for the single-beat instance
   initial begin : mon1
      beat_t e;
      int    low_run;
      low_run = 0;
      forever begin
         @(negedge wb_clk); #1;
         if (stb1 && ack1) begin
            if (q1.size() == 0) begin
               total++;
               bad++;
               $display("FAIL d1_extra_beat: got beat at adr %0h expected none", adr1);
            end else begin
               e = q1.pop_front();
               chk("d1_adr", adr1, e.adr);
               chk("d1_we",  we1,  e.we);
               chk("d1_cti", cti1, e.cti);
               chk("d1_bte", bte1, e.bte);
               if (e.we) chk("d1_wdat", dat1_o, e.dat);
            end
            beats1++;
         end
         if (busy1 && !cyc1) begin
            low_run++;
         end else if (busy1 && cyc1) begin
            if (low_run > 0) chk("d1_gap", low_run, 1);
            low_run = 0;
         end else begin
            low_run = 0;
         end
      end
   end

   initial begin : main
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      repeat (3) @(negedge wb_clk);
      #2;
      chk("rst_cyc",   cyc0, 0);
      chk("rst_stb",   stb0, 0);
      chk("rst_busy",  busy0, 0);
      chk("rst_done",  done0, 0);
      chk("rst_err",   err0, 0);
      chk("rst_tmo",   tmo0, 0);
      chk("rst_adr",   adr0, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge wb_clk);
      #2;
      chk("idle_no_start", busy0, 0);

      // Single-beat classic cycles
      beats1 = 0;
      push_pass(1, 1, 8, 1000);
      pulse_start(1);
      wait_done(1, 500, "S1");
      chk("S1_err",   err1, 0);
      chk("S1_tmo",   tmo1, 0);
      chk("S1_left",  q1.size(), 0);
      chk("S1_beats", beats1, 16);

      // Zero-wait full pass
      beats0 = 0; wr_idx = 0; rd_idx = 0;
      push_pass(0, 4, 16, 1000);
      pulse_start(0);
      wait_done(0, 3000, "A");
      chk("A_err",   err0, 0);
      chk("A_tmo",   tmo0, 0);
      chk("A_left",  q0.size(), 0);
      chk("A_beats", beats0, 128);

      // Two corrupted read beats
      beats0 = 0; wr_idx = 0; rd_idx = 0; corrupt_en = 1;
      push_pass(0, 4, 16, 1000);
      pulse_start(0);
      wait_done(0, 3000, "B");
      corrupt_en = 0;
      chk("B_err",  err0, 2);
      chk("B_tmo",  tmo0, 0);
      chk("B_left", q0.size(), 0);
      repeat (5) @(negedge wb_clk);
      #2;
      chk("B_err_hold", err0, 2);

      // Slave never acks write beat 3
      beats0 = 0; wr_idx = 0; rd_idx = 0; hang_cycles = 0; noack_en = 1;
      push_pass(0, 4, 16, 3);
      pulse_start(0);
      wait_done(0, 500, "C");
      noack_en = 0;
      chk("C_hang",  hang_cycles, 16);
      chk("C_tmo",   tmo0, 1);
      chk("C_err",   err0, 0);
      chk("C_left",  q0.size(), 0);
      chk("C_beats", beats0, 3);
      chk("C_cyc",   cyc0, 0);

      // Random stalls, stray acks, start pulses while busy
      beats0 = 0; wr_idx = 0; rd_idx = 0; stall_en = 1; spur_en = 1;
      push_pass(0, 4, 16, 1000);
      pulse_start(0);
      repeat (2) @(negedge wb_clk);
      #2;
      chk("D_tmo_clr", tmo0, 0);
      poke_en = 1;
      fork
         begin
            while (poke_en) begin
               repeat ($urandom_range(5, 30)) @(negedge wb_clk);
               if (poke_en && busy0) begin
                  start0 = 1'b1;
                  @(negedge wb_clk);
                  start0 = 1'b0;
               end
            end
         end
      join_none
      wait_done(0, 6000, "D");
      poke_en = 0; stall_en = 0; spur_en = 0;
      chk("D_err",   err0, 0);
      chk("D_tmo",   tmo0, 0);
      chk("D_left",  q0.size(), 0);
      chk("D_beats", beats0, 128);
      repeat (40) @(negedge wb_clk);

      // Reset during write burst 2, then restart from the beginning
      beats0 = 0; wr_idx = 0; rd_idx = 0;
      push_pass(0, 4, 16, 1000);
      pulse_start(0);
      for (int i = 0; i < 200 && beats0 < 9; i++) @(negedge wb_clk);
      chk("E_reach_burst2", beats0 >= 9, 1);
      @(negedge wb_clk);
      chk("E_cyc_pre", cyc0, 1);
      rst_n = 1'b0;
      #1;
      chk("E_cyc_rst",  cyc0, 0);
      chk("E_stb_rst",  stb0, 0);
      chk("E_busy_rst", busy0, 0);
      #1;
      q0.delete();
      @(negedge wb_clk);
      rst_n = 1'b1;
      repeat (3) @(negedge wb_clk);
      #2;
      chk("E_stay_idle", busy0, 0);
      beats0 = 0; wr_idx = 0; rd_idx = 0;
      push_pass(0, 4, 16, 1000);
      pulse_start(0);
      wait_done(0, 3000, "E");
      chk("E_err",   err0, 0);
      chk("E_left",  q0.size(), 0);
      chk("E_beats", beats0, 128);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
